// File: rtl/mac_filter_cam.sv
// AXI-Stream receive-path destination-MAC filter with a programmable address table.
// Optional multicast acceptance is enabled by defining MAC_FILTER_MCAST_EN.
module mac_filter_cam #(
  parameter int          DATA_W      = 32,
  parameter int          NUM_ADDR    = 4,
  parameter logic [47:0] DEFAULT_MAC = 48'hDEADBEEF1234,
  parameter int          CNT_W       = 16,
  localparam int         IDX_W       = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tlast,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tlast,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [47:0]       cfg_mac,
  input  logic              cfg_valid,
  input  logic              promisc,
  input  logic              bcast_en,
`ifdef MAC_FILTER_MCAST_EN
  input  logic              mcast_en,
`endif
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  runt_cnt
);

  // state | meaning
  // HDR   | collecting the 6 destination-address beats
  // FLUSH | replaying the buffered header beats downstream
  // PASS  | cut-through of the remaining frame
  // DROP  | discarding the remaining frame up to tlast
  typedef enum logic [1:0] {HDR, FLUSH, PASS, DROP} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] hdr_buf [6];
  logic [2:0]        hdr_cnt;
  logic [2:0]        flush_idx;
  logic              out_vld_r;
  logic [DATA_W-1:0] out_data_r;
  logic              ready_en;

  logic [47:0]         tbl_mac [NUM_ADDR];
  logic [NUM_ADDR-1:0] tbl_vld;

  logic [47:0]       da;
  logic              hit, is_bcast, match;
  logic              hdr_acc, is_runt, decide;
  logic [DATA_W-1:0] flush_data;

  assign hdr_acc = (state == HDR) && in_tvalid && ready_en;
  assign is_runt = hdr_acc && in_tlast;
  assign decide  = hdr_acc && !in_tlast && (hdr_cnt == 3'd5);

  assign da = {hdr_buf[0][7:0], hdr_buf[1][7:0], hdr_buf[2][7:0],
               hdr_buf[3][7:0], hdr_buf[4][7:0], in_tdata[7:0]};

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_ADDR; i++) begin
      if (tbl_vld[i] && (tbl_mac[i] == da)) hit = 1'b1;
    end
    is_bcast = &da;
    match    = promisc | (bcast_en & is_bcast) | hit;
`ifdef MAC_FILTER_MCAST_EN
    // Group bit is bit 0 of the first wire byte.
    match    = match | (mcast_en & da[40] & ~is_bcast);
`endif
  end

  always_comb begin
    flush_data = '0;
    for (int i = 0; i < 6; i++) begin
      if (flush_idx == 3'(i)) flush_data = hdr_buf[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_tready  = 1'b0;
    out_tvalid = out_vld_r;
    out_tdata  = out_data_r;
    out_tlast  = 1'b0;
    case (state)
      HDR: begin
        in_tready = ready_en;
        if (is_runt)     state_nxt = HDR;
        else if (decide) state_nxt = match ? FLUSH : DROP;
      end
      FLUSH: begin
        if (out_tready && (flush_idx == 3'd6)) state_nxt = PASS;
      end
      PASS: begin
        out_tvalid = in_tvalid;
        out_tdata  = in_tdata;
        out_tlast  = in_tlast;
        in_tready  = out_tready;
        if (in_tvalid && out_tready && in_tlast) state_nxt = HDR;
      end
      DROP: begin
        in_tready = 1'b1;
        if (in_tvalid && in_tlast) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  // in_tready must stay low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt <= '0;
      for (int i = 0; i < 6; i++) hdr_buf[i] <= '0;
    end else if (hdr_acc) begin
      for (int i = 0; i < 6; i++) begin
        if (hdr_cnt == 3'(i)) hdr_buf[i] <= in_tdata;
      end
      if (is_runt || decide) hdr_cnt <= '0;
      else                   hdr_cnt <= hdr_cnt + 3'd1;
    end
  end

  // Header replay: flush_idx points at the next buffer entry to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_r  <= 1'b0;
      out_data_r <= '0;
      flush_idx  <= '0;
    end else if (decide && match) begin
      out_vld_r  <= 1'b1;
      out_data_r <= hdr_buf[0];
      flush_idx  <= 3'd1;
    end else if ((state == FLUSH) && out_tready) begin
      if (flush_idx == 3'd6) begin
        out_vld_r <= 1'b0;
      end else begin
        out_data_r <= flush_data;
        flush_idx  <= flush_idx + 3'd1;
      end
    end
  end

  // A write concurrent with a decision lands after it, so the decision sees the old table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ADDR; i++) tbl_mac[i] <= (i == 0) ? DEFAULT_MAC : 48'h0;
      tbl_vld <= NUM_ADDR'(1);
    end else begin
      for (int i = 0; i < NUM_ADDR; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          tbl_mac[i] <= cfg_mac;
          tbl_vld[i] <= cfg_valid;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
      runt_cnt <= '0;
    end else if (cnt_clr) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
      runt_cnt <= '0;
    end else begin
      if (decide && match && !(&pass_cnt))  pass_cnt <= pass_cnt + 1'b1;
      if (decide && !match && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (is_runt && !(&runt_cnt))          runt_cnt <= runt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_filter_cam.sv
// Scoreboard bench for mac_filter_cam: expected beats queued at stimulus, popped at output.
module tb_mac_filter_cam;
  localparam int DATA_W   = 32;
  localparam int NUM_ADDR = 4;
  localparam int CNT_W    = 16;
  localparam int IDX_W    = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_tvalid, in_tready, in_tlast;
  logic [DATA_W-1:0] in_tdata;
  logic              out_tvalid, out_tready, out_tlast;
  logic [DATA_W-1:0] out_tdata;
  logic              cfg_we, cfg_valid;
  logic [IDX_W-1:0]  cfg_idx;
  logic [47:0]       cfg_mac;
  logic              promisc, bcast_en, cnt_clr;
`ifdef MAC_FILTER_MCAST_EN
  logic              mcast_en;
`endif
  logic [CNT_W-1:0]  pass_cnt, drop_cnt, runt_cnt;

  int    compared = 0;
  int    mismatched = 0;
  beat_t exp_q[$];
  int    exp_pass = 0, exp_drop = 0, exp_runt = 0;
  bit    toggle_en = 1'b0;

  mac_filter_cam #(.DATA_W(DATA_W), .NUM_ADDR(NUM_ADDR), .DEFAULT_MAC(48'hDEADBEEF1234),
                   .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mac(cfg_mac), .cfg_valid(cfg_valid),
    .promisc(promisc), .bcast_en(bcast_en),
`ifdef MAC_FILTER_MCAST_EN
    .mcast_en(mcast_en),
`endif
    .cnt_clr(cnt_clr),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .runt_cnt(runt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_tready = toggle_en ? ~out_tready : 1'b1;
    end
  end

  // Output monitor: every downstream handshake must match the head of the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_tvalid && out_tready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_beat: got data=%h last=%b, required no output", out_tdata, out_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({out_tlast, out_tdata} !== e) begin
            mismatched++;
            $display("FAIL out_beat: got data=%h last=%b, required data=%h last=%b",
                     out_tdata, out_tlast, e.data, e.last);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bq_t mk_frame(input logic [47:0] da, input int len);
    bq_t   f;
    string s = "Hello";
    for (int i = 0; i < 6; i++) f.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 5; i++) f.push_back(s[i]);
    while (f.size() < len) f.push_back(8'(f.size()));
    while (f.size() > len) void'(f.pop_back());
    return f;
  endfunction

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [47:0] mac, input logic v);
    cfg_we = 1'b1; cfg_idx = idx; cfg_mac = mac; cfg_valid = v;
    cycles(1);
    cfg_we = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input bit pass, input int gap_pct);
    logic [DATA_W-1:0] d;
    logic              hs;
    int                w;
    for (int i = 0; i < f.size(); i++) begin
      if (gap_pct > 0) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          in_tvalid = 1'b0;
          cycles(1);
        end
      end
      d = $urandom;
      d[7:0] = f[i];
      in_tvalid = 1'b1;
      in_tdata  = d;
      in_tlast  = (i == f.size() - 1);
      if (pass) exp_q.push_back({in_tlast, d});
      w = 0;
      forever begin
        @(negedge clk);
        hs = in_tready;
        cycles(1);
        if (hs) break;
        w++;
        if (w > 200) begin
          compared++; mismatched++;
          $display("FAIL in_handshake: got in_tready=0 for 200 cycles, required acceptance of beat %0d", i);
          break;
        end
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain_check(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      cycles(1);
      w++;
    end
    cycles(4);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    compared++;
    if (pass_cnt !== CNT_W'(exp_pass)) begin
      mismatched++;
      $display("FAIL %s_pass_cnt: got %0d, required %0d", name, pass_cnt, exp_pass);
    end
    compared++;
    if (drop_cnt !== CNT_W'(exp_drop)) begin
      mismatched++;
      $display("FAIL %s_drop_cnt: got %0d, required %0d", name, drop_cnt, exp_drop);
    end
    compared++;
    if (runt_cnt !== CNT_W'(exp_runt)) begin
      mismatched++;
      $display("FAIL %s_runt_cnt: got %0d, required %0d", name, runt_cnt, exp_runt);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_mac = '0; cfg_valid = 1'b0;
    promisc = 1'b0; bcast_en = 1'b0; cnt_clr = 1'b0;
`ifdef MAC_FILTER_MCAST_EN
    mcast_en = 1'b0;
`endif
    cycles(3);
    compared++;
    if (in_tready !== 1'b0) begin
      mismatched++; $display("FAIL reset_in_tready: got %b, required 0", in_tready);
    end
    compared++;
    if ({out_tvalid, out_tlast, out_tdata} !== '0) begin
      mismatched++;
      $display("FAIL reset_out: got valid=%b last=%b data=%h, required all 0", out_tvalid, out_tlast, out_tdata);
    end
    compared++;
    if ({pass_cnt, drop_cnt, runt_cnt} !== '0) begin
      mismatched++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d, required 0/0/0", pass_cnt, drop_cnt, runt_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    compared++;
    if (in_tready !== 1'b1) begin
      mismatched++; $display("FAIL post_reset_in_tready: got %b, required 1", in_tready);
    end
  endtask

  task automatic test_basic_pass;
    send_frame(mk_frame(48'hDEADBEEF1234, 20), 1'b1, 0);
    exp_pass++;
    drain_check("basic");
  endtask

  task automatic test_drop_promisc;
    send_frame(mk_frame(48'h010203040506, 20), 1'b0, 0);
    exp_drop++;
    drain_check("drop");
    promisc = 1'b1;
    send_frame(mk_frame(48'h010203040506, 20), 1'b1, 0);
    exp_pass++;
    drain_check("promisc");
    promisc = 1'b0;
  endtask

  task automatic test_cfg_write;
    cfg_write(2'd2, 48'h0A3512345600, 1'b1);
    send_frame(mk_frame(48'h0A3512345600, 16), 1'b1, 0);
    exp_pass++;
    drain_check("cfg_idx2");
    cfg_write(2'd0, 48'hDEADBEEF1234, 1'b0);
    send_frame(mk_frame(48'hDEADBEEF1234, 20), 1'b0, 0);
    exp_drop++;
    drain_check("cfg_idx0_off");
  endtask

  task automatic test_runt;
    send_frame(mk_frame(48'h0A3512345600, 4), 1'b0, 0);
    exp_runt++;
    drain_check("runt4");
    send_frame(mk_frame(48'h0A3512345600, 6), 1'b0, 0);
    exp_runt++;
    drain_check("runt6");
    send_frame(mk_frame(48'h0A3512345600, 20), 1'b1, 0);
    exp_pass++;
    drain_check("after_runt");
    send_frame(mk_frame(48'h0A3512345600, 7), 1'b1, 0);
    exp_pass++;
    drain_check("min7");
  endtask

  task automatic test_backpressure;
    toggle_en = 1'b1;
    send_frame(mk_frame(48'h0A3512345600, 20), 1'b1, 30);
    send_frame(mk_frame(48'h0A3512345600, 12), 1'b1, 30);
    send_frame(mk_frame(48'h123456789ABC, 10), 1'b0, 30);
    exp_pass += 2;
    exp_drop++;
    drain_check("backpressure");
    toggle_en = 1'b0;
    cycles(2);
  endtask

  task automatic test_bcast;
    send_frame(mk_frame(48'hFFFFFFFFFFFF, 12), 1'b0, 0);
    exp_drop++;
    drain_check("bcast_off");
    bcast_en = 1'b1;
    send_frame(mk_frame(48'hFFFFFFFFFFFF, 12), 1'b1, 0);
    exp_pass++;
    drain_check("bcast_on");
    bcast_en = 1'b0;
`ifdef MAC_FILTER_MCAST_EN
    mcast_en = 1'b1;
    send_frame(mk_frame(48'h01005E000001, 12), 1'b1, 0);
    exp_pass++;
    drain_check("mcast_on");
    mcast_en = 1'b0;
`else
    send_frame(mk_frame(48'h01005E000001, 12), 1'b0, 0);
    exp_drop++;
    drain_check("mcast_absent");
`endif
  endtask

  task automatic test_cnt_clr;
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    exp_pass = 0; exp_drop = 0; exp_runt = 0;
    drain_check("cnt_clr");
    send_frame(mk_frame(48'h0A3512345600, 9), 1'b1, 0);
    exp_pass++;
    drain_check("after_clr");
  endtask

  initial begin
    test_reset;
    test_basic_pass;
    test_drop_promisc;
    test_cfg_write;
    test_runt;
    test_backpressure;
    test_bcast;
    test_cnt_clr;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
